cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Control stage directly upstream of the direct-mapped, 128-bit-line data cache. It accepts CPU word reads and writes and splits the word address into tag, index and offset for the cache.
- On a read miss it fetches the line from 32-bit main memory as four single-word beats, assembles it, and pulses refill.
- Writes are write-through with no write-allocate.
- Stalls the CPU until each request completes.

Parameters:
- ADDR_WIDTH, 10, CPU word-address width (1024-word memory).
- TAG_WIDTH, 3, tag field, cpu_addr[9:7].
- INDEX_WIDTH, 5, index field, cpu_addr[6:2].
- OFFSET_WIDTH, 2, word-in-line field, cpu_addr[1:0].
- DATA_WIDTH, 32, word width.
- LINE_WIDTH, 128, cache line width (4 words).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_read  in  1  read request; held stable while stall=1
- cpu_write  in  1  write request; held stable while stall=1
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_write_data  in  DATA_WIDTH  store data
- stall  out  1  CPU must hold the request and not advance
- hit  in  1  cache hit for the presented tag/index
- tag  out  TAG_WIDTH  cpu_addr[9:7]
- index  out  INDEX_WIDTH  cpu_addr[6:2]
- offset  out  OFFSET_WIDTH  cpu_addr[1:0]
- refill  out  1  one-cycle line write into the cache
- update  out  1  one-cycle word write into the cache
- line_data  out  LINE_WIDTH  assembled line; word k occupies bits [32k+31:32k]
- write_data  out  DATA_WIDTH  equals cpu_write_data
- mem_read  out  1  memory read request, held until mem_ready
- mem_write  out  1  memory write request, held until mem_ready
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_write_data  out  DATA_WIDTH  equals cpu_write_data
- mem_read_data  in  DATA_WIDTH  valid when mem_ready=1 during a read
- mem_ready  in  1  completes the current memory beat

Behaviour:
- Synchronous active-high reset; clock is clk.
- FSM states: IDLE, REFILL, FILL, WRITE_MEM. Reset, including mid-operation, forces:
  - state=IDLE, beat counter=0;
  - refill=update=mem_read=mem_write=0 from the following cycle;
  - any in-flight memory beat abandoned;
  - line buffer contents left unchanged; they are don't-care.
- tag/index/offset are combinational slices of cpu_addr in every state.
- IDLE:
  - Write has priority if cpu_read and cpu_write are both 1.
  - cpu_write: stall=1 and next state is WRITE_MEM. If hit=1, update=1 this cycle, so the cache word is written at this edge.
  - cpu_read and hit: stall=0; data comes from the cache combinationally in zero cycles.
  - cpu_read and !hit: stall=1, next state is REFILL with beat=0.
  - No request: stall=0.
- REFILL:
  - mem_read=1, mem_addr={tag,index,beat}, stall=1.
  - On mem_ready: buffer[beat]<=mem_read_data and beat increments.
  - If mem_ready arrives at beat=3, next state is FILL; otherwise stay in REFILL.
  - beat is 2 bits and wraps 3->0 at the FILL transition.
  - Wait states (mem_ready=0) are unbounded; all outputs hold.
- FILL:
  - refill=1 for exactly one cycle, line_data=buffer, stall=1, next state IDLE.
  - Next cycle in IDLE, hit=1 and the read completes with stall=0.
- Read-miss penalty with zero-wait memory: 6 stalled cycles (detect, 4 beats, fill), then the hit cycle.
- WRITE_MEM:
  - mem_write=1, mem_addr=cpu_addr, mem_write_data=cpu_write_data.
  - stall=!mem_ready. On mem_ready, next state is IDLE.
  - The CPU advances on that same edge.
  - update is never asserted here, so the cache word is written exactly once.
- update and refill are never high in the same cycle.
- mem_read and mem_write are never high in the same cycle.
- A write miss does not allocate and does not touch the cache.
- cpu_read/cpu_write changing while stall=1 is a protocol violation. Behaviour in that case is undefined, but the FSM must still return to IDLE.

Decomposition:
- Shared package cache_pkg holds:
  - field-width constants (TAG/INDEX/OFFSET/DATA/LINE);
  - the FSM state enum;
  - WORDS_PER_LINE=4.
- One natural sub-module: line_assembler, a beat counter plus 4x32 buffer that raises a last-beat flag.

Test Plan:
- Read, cache hit: cpu_read=1, cpu_addr=0x085, hit=1 -> stall=0; tag=1, index=1, offset=1; no mem_read.
- Read miss, zero-wait memory: cpu_addr=0x1A6, hit=0, mem_read_data = 0xA0,0xA1,0xA2,0xA3 on four consecutive cycles.
  - mem_addr sequence 0x1A4..0x1A7.
  - refill pulses one cycle with line_data=0x000000A3_000000A2_000000A1_000000A0.
  - stall=1 for 6 cycles.
- Refill with wait states: mem_ready low 2 cycles before each beat -> each mem_addr held 3 cycles, refill single pulse, stall=1 for 14 cycles.
- Write hit: cpu_write=1, addr=0x020, data=0xDEADBEEF, hit=1, mem_ready after 3 cycles.
  - update=1 only in the first cycle; mem_write held 3 cycles with mem_addr=0x020.
  - stall falls in the mem_ready cycle.
- Write miss: hit=0 -> update never asserted, refill never asserted, mem_write issued.
- Reset mid-refill: assert reset after beat 1 -> next cycle state IDLE, mem_read=0, refill=0. A new miss restarts at beat 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller slice.
// Holds the address field widths, line geometry and the controller FSM state type.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH     = 10;
  localparam int unsigned TAG_WIDTH      = 3;
  localparam int unsigned INDEX_WIDTH    = 5;
  localparam int unsigned OFFSET_WIDTH   = 2;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned LINE_WIDTH     = DATA_WIDTH * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StFill,
    StWriteMem
  } state_e;

endpackage

// File: rtl/line_assembler.sv
// Line assembler: collects the single-word beats of a line refill.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - return the beat counter to word 0
//   load        - a beat is valid this cycle; store load_data at the current beat
//   load_data   - incoming memory word
//   beat        - word number of the beat currently being fetched
//   last        - load of the final word of the line this cycle
//   line        - assembled line, word k in bits [32k+31:32k]
module line_assembler
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic [OFFSET_WIDTH-1:0] beat,
  output logic                    last,
  output logic [LINE_WIDTH-1:0]   line
);

  logic [OFFSET_WIDTH-1:0] beat_q;
  logic [DATA_WIDTH-1:0]   buffer_q [WORDS_PER_LINE];

  // The counter wraps 3->0 by itself on the last beat, so the next miss starts at word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q <= '0;
    end else if (clear) begin
      beat_q <= '0;
    end else if (load) begin
      beat_q <= beat_q + OFFSET_WIDTH'(1);
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      buffer_q[beat_q] <= load_data;
    end
  end

  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_word
    assign line[k*DATA_WIDTH +: DATA_WIDTH] = buffer_q[k];
  end

  assign beat = beat_q;
  assign last = load && (beat_q == OFFSET_WIDTH'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_controller.sv
// Cache controller in front of a direct-mapped data cache with 4-word lines.
// Splits the CPU word address into tag/index/offset, refills a line from 32-bit memory on a
// read miss (four beats, then a one-cycle refill pulse), and writes through to memory on every
// store without allocating. The CPU is stalled until each request completes.
// Ports:
//   clk, reset                    - clock and synchronous active-high reset
//   cpu_read/cpu_write/cpu_addr/  - CPU request, held stable while stall=1
//   cpu_write_data, stall
//   hit, tag, index, offset       - cache lookup
//   refill, update, line_data,    - cache line / word writes
//   write_data
//   mem_read, mem_write, mem_addr,- main memory handshake, one word per mem_ready
//   mem_write_data, mem_read_data,
//   mem_ready
module cache_controller
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_write_data,
  output logic                    stall,
  input  logic                    hit,
  output logic [TAG_WIDTH-1:0]    tag,
  output logic [INDEX_WIDTH-1:0]  index,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    refill,
  output logic                    update,
  output logic [LINE_WIDTH-1:0]   line_data,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  input  logic                    mem_ready
);

  state_e                  state_q;
  logic [OFFSET_WIDTH-1:0] beat;
  logic                    last_beat;
  logic                    beat_load;

  assign tag    = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign index  = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign offset = cpu_addr[OFFSET_WIDTH-1:0];

  assign write_data     = cpu_write_data;
  assign mem_write_data = cpu_write_data;

  assign beat_load = (state_q == StRefill) && mem_ready;

  line_assembler u_line_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == StIdle),
    .load      (beat_load),
    .load_data (mem_read_data),
    .beat      (beat),
    .last      (last_beat),
    .line      (line_data)
  );

  // Stores take priority over loads when both are requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_write) begin
            state_q <= StWriteMem;
          end else if (cpu_read && !hit) begin
            state_q <= StRefill;
          end
        end
        StRefill: begin
          if (last_beat) begin
            state_q <= StFill;
          end
        end
        StFill: begin
          state_q <= StIdle;
        end
        StWriteMem: begin
          if (mem_ready) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs are decoded from the state; the IDLE decisions also depend on the live request
  // so a hit completes in zero cycles and a write hit updates the cache on the first edge.
  always_comb begin
    stall     = 1'b0;
    update    = 1'b0;
    refill    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = cpu_addr;
    unique case (state_q)
      StIdle: begin
        stall  = cpu_write || (cpu_read && !hit);
        update = cpu_write && hit;
      end
      StRefill: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = {tag, index, beat};
      end
      StFill: begin
        stall  = 1'b1;
        refill = 1'b1;
      end
      StWriteMem: begin
        stall     = !mem_ready;
        mem_write = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic         clk;
  logic         reset;
  logic         cpu_read;
  logic         cpu_write;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_write_data;
  logic         stall;
  logic         hit;
  logic [2:0]   tag;
  logic [4:0]   index;
  logic [1:0]   offset;
  logic         refill;
  logic         update;
  logic [127:0] line_data;
  logic [31:0]  write_data;
  logic         mem_read;
  logic         mem_write;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_write_data;
  logic [31:0]  mem_read_data;
  logic         mem_ready;

  cache_controller dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_addr       (cpu_addr),
    .cpu_write_data (cpu_write_data),
    .stall          (stall),
    .hit            (hit),
    .tag            (tag),
    .index          (index),
    .offset         (offset),
    .refill         (refill),
    .update         (update),
    .line_data      (line_data),
    .write_data     (write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main memory as seen by the responder, and the reference copy updated from CPU stores.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  // Cache directory model: drives hit, filled on refill.
  logic        c_valid [32];
  logic [2:0]  c_tag   [32];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [9:0]  addr;
    logic        hit;
    logic [31:0] data;
    logic        stall;
    logic        upd;
    logic [2:0]  tag;
    logic [4:0]  idx;
    logic [1:0]  off;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_hit(input logic [9:0] a);
    return c_valid[a[6:2]] && (c_tag[a[6:2]] == a[9:7]);
  endfunction

  function automatic logic [127:0] exp_line(input logic [9:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = ref_mem[a - 10'(a % 4) + 10'(k)];
    return l;
  endfunction

  // Runs one CPU request to completion, acting as cache directory and main memory, and
  // checks the transaction-level outcome: stall length, memory traffic, refill and update.
  task automatic run_req(input logic wr, input logic rd, input logic [9:0] addr,
                         input logic [31:0] data, input int w);
    int stalls = 0, refills = 0, rd_cyc = 0, wr_cyc = 0, upds = 0, beats = 0;
    int wait_left = w;
    logic done = 1'b0;
    logic hit0;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_write_data = data;
    hit0 = model_hit(addr);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      hit = model_hit(addr);
      mem_read_data = $urandom;
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          if (mem_read) mem_read_data = mem[mem_addr];
        end
      end
      @(negedge clk);
      chk("excl_upd_refill", update && refill, 1'b0);
      chk("excl_rd_wr", mem_read && mem_write, 1'b0);
      if (mem_read) begin
        rd_cyc++;
        chk("rd_mem_addr", mem_addr, {addr[9:2], 2'(beats)});
        if (mem_ready) beats++;
      end
      if (mem_write) begin
        wr_cyc++;
        chk("wr_mem_addr", mem_addr, addr);
        chk("wr_mem_data", mem_write_data, data);
        if (mem_ready) mem[mem_addr] = mem_write_data;
      end
      if (update) upds++;
      if (refill) begin
        refills++;
        chk("line_data", line_data, exp_line(addr));
        c_valid[addr[6:2]] = 1'b1;
        c_tag[addr[6:2]]   = addr[9:7];
      end
      if (stall) stalls++;
      else done = 1'b1;
      if (mem_read || mem_write) wait_left = mem_ready ? w : wait_left - 1;
      @(posedge clk);
      #1;
    end
    cpu_read = 1'b0; cpu_write = 1'b0; mem_ready = 1'b0;
    chk("req_completes", done, 1'b1);
    if (wr) begin
      ref_mem[addr] = data;
      chk("wr_stall_cycles", stalls, 1 + w);
      chk("wr_updates", upds, hit0 ? 1 : 0);
      chk("wr_refills", refills, 0);
      chk("wr_mem_write_cycles", wr_cyc, w + 1);
      chk("wr_mem_read_cycles", rd_cyc, 0);
    end else if (rd && hit0) begin
      chk("rdhit_stall_cycles", stalls, 0);
      chk("rdhit_mem_read_cycles", rd_cyc, 0);
      chk("rdhit_refills", refills, 0);
    end else if (rd) begin
      chk("miss_stall_cycles", stalls, 6 + 4 * w);
      chk("miss_refills", refills, 1);
      chk("miss_mem_read_cycles", rd_cyc, 4 * (w + 1));
      chk("miss_beats", beats, 4);
      chk("miss_updates", upds, 0);
      chk("miss_mem_write_cycles", wr_cyc, 0);
    end
  endtask

  initial begin
    logic [9:0] recent [8];
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_write_data = '0;
    hit = 1'b0; mem_read_data = '0; mem_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 32; i++) begin
      c_valid[i] = 1'b0;
      c_tag[i]   = '0;
    end

    //          rd    wr    addr     hit   data          stall upd   tag   idx    off
    vecs[0] = '{1'b1, 1'b0, 10'h085, 1'b1, 32'h0,        1'b0, 1'b0, 3'd1, 5'd1,  2'd1};
    vecs[1] = '{1'b1, 1'b0, 10'h1A6, 1'b0, 32'h0,        1'b1, 1'b0, 3'd3, 5'd9,  2'd2};
    vecs[2] = '{1'b0, 1'b1, 10'h020, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 3'd0, 5'd8,  2'd0};
    vecs[3] = '{1'b0, 1'b1, 10'h3FF, 1'b0, 32'h12345678, 1'b1, 1'b0, 3'd7, 5'd31, 2'd3};
    vecs[4] = '{1'b1, 1'b1, 10'h155, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 3'd2, 5'd21, 2'd1};
    vecs[5] = '{1'b0, 1'b0, 10'h000, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0, 5'd0,  2'd0};
    vecs[6] = '{1'b1, 1'b1, 10'h2AA, 1'b0, 32'h0BADCAFE, 1'b1, 1'b0, 3'd5, 5'd10, 2'd2};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_stall", stall, 1'b0);
    chk("reset_refill", refill, 1'b0);
    chk("reset_update", update, 1'b0);
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);

    // Single-cycle decode in IDLE.
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cpu_read = vecs[v].rd; cpu_write = vecs[v].wr; cpu_addr = vecs[v].addr;
      cpu_write_data = vecs[v].data; hit = vecs[v].hit;
      @(negedge clk);
      chk("vec_stall", stall, vecs[v].stall);
      chk("vec_update", update, vecs[v].upd);
      chk("vec_tag", tag, vecs[v].tag);
      chk("vec_index", index, vecs[v].idx);
      chk("vec_offset", offset, vecs[v].off);
      chk("vec_idle_mem", {mem_read, mem_write, refill}, 3'b000);
      chk("vec_write_data", {write_data, mem_write_data}, {vecs[v].data, vecs[v].data});
      cpu_read = 1'b0; cpu_write = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Read hit at 0x085.
    c_valid[1] = 1'b1; c_tag[1] = 3'd1;
    run_req(1'b0, 1'b1, 10'h085, 32'h0, 0);

    // Read miss at 0x1A6, zero-wait memory with known line contents.
    for (int k = 0; k < 4; k++) begin
      mem[10'h1A4 + 10'(k)]     = 32'hA0 + 32'(k);
      ref_mem[10'h1A4 + 10'(k)] = 32'hA0 + 32'(k);
    end
    run_req(1'b0, 1'b1, 10'h1A6, 32'h0, 0);
    chk("miss_line_const", exp_line(10'h1A6), 128'h000000A3_000000A2_000000A1_000000A0);

    // Refill with two wait cycles before every beat.
    run_req(1'b0, 1'b1, 10'h2C1, 32'h0, 2);

    // Write hit at 0x020, memory ready in the third WRITE_MEM cycle.
    c_valid[8] = 1'b1; c_tag[8] = 3'd0;
    run_req(1'b1, 1'b0, 10'h020, 32'hDEADBEEF, 2);
    chk("mem_after_write", mem[10'h020], 32'hDEADBEEF);

    // Write miss: no allocate, and a later read of the same line still misses.
    run_req(1'b1, 1'b0, 10'h3B4, 32'h55AA55AA, 1);
    chk("write_miss_no_alloc", model_hit(10'h3B4), 1'b0);
    run_req(1'b0, 1'b1, 10'h3B4, 32'h0, 0);

    // Reset after beat 1 of a refill, then the same miss restarts from beat 0.
    cpu_read = 1'b1; cpu_addr = 10'h0F3; hit = 1'b0; mem_ready = 1'b1;
    mem_read_data = 32'h11111111;
    @(posedge clk); #1;
    chk("rst_mid_beat0_addr", mem_addr, 10'h0F0);
    @(posedge clk); #1;
    chk("rst_mid_beat1_addr", mem_addr, 10'h0F1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_mem_read", mem_read, 1'b0);
    chk("rst_mid_refill", refill, 1'b0);
    chk("rst_mid_stall", stall, 1'b1);
    run_req(1'b0, 1'b1, 10'h0F3, 32'h0, 0);

    // Random traffic with address reuse so hits occur.
    for (int i = 0; i < 8; i++) recent[i] = 10'($urandom);
    for (int i = 0; i < 60; i++) begin
      logic [9:0]  a;
      logic        w_en;
      logic        r_en;
      a = ($urandom_range(0, 1) == 1) ? recent[$urandom_range(0, 7)] : 10'($urandom);
      recent[i % 8] = a;
      w_en = ($urandom_range(0, 2) == 0);
      r_en = w_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      run_req(w_en, r_en, a, $urandom, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
